// File: rtl/timer_counter_pkg.sv
`default_nettype none
// ============================================================================
// timer_counter_pkg
//   Shared register map, CTRL bit positions, MODE encodings, FSM state
//   encodings and a byte-lane merge helper for the MMIO timer.
//   Rev 1.0 - initial release
// ============================================================================
package timer_counter_pkg;

  // Register word indices (byte address bits 3:2)
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // CTRL bit positions; everything above CTRL_IM reads as zero
  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM       = 3;
  localparam int CTRL_WIDTH    = 4;

  // MODE encodings; the two unlisted codes behave as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // Counter FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  // Replace only the byte lanes flagged in 'lanes'
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  lanes);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage : timer_counter_pkg
`default_nettype wire

// File: rtl/timer_counter_core.sv
`default_nettype none
// ============================================================================
// timer_counter_core
//   One timer channel: CTRL/PRESET/COUNT register file plus the
//   IDLE/LOAD/CNT/INT counting FSM and the registered interrupt output.
//   Rev 1.0 - initial release
// ============================================================================
module timer_counter_core
  import timer_counter_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic [1:0]  idx,
  input  logic        we,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  state_t                  r_state, w_state_nxt;
  logic [CTRL_WIDTH-1:0]   r_ctrl, w_ctrl_nxt;
  logic [31:0]             r_preset, w_preset_nxt;
  logic [31:0]             r_count, w_count_nxt;
  logic                    r_intflag, w_intflag_nxt;
  logic                    r_irq;

  logic                    w_wr_any;
  logic                    w_ctrl_wr;
  logic                    w_preset_wr;
  logic                    w_reload;
  logic                    w_fsm_set_flag;
  logic                    w_fsm_clr_flag;
  logic                    w_fsm_clr_en;

  // A write with no lanes enabled is a no-op, including its flag-clear side effect
  assign w_wr_any    = we & (|byteen);
  assign w_ctrl_wr   = w_wr_any & (idx == REG_CTRL);
  assign w_preset_wr = w_wr_any & (idx == REG_PRESET);
  assign w_reload    = (r_ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB] == MODE_RELOAD);

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state, COUNT update and flag/EN side effects from pre-edge register values
  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_fsm_set_flag = 1'b0;
    w_fsm_clr_flag = 1'b0;
    w_fsm_clr_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_ctrl[CTRL_EN]) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_count_nxt = r_preset;
        w_state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!r_ctrl[CTRL_EN]) begin
          w_state_nxt = ST_IDLE;
        end else if (r_count > 32'd1) begin
          w_count_nxt = r_count - 32'd1;
        end else begin
          // Covers PRESET of 0 or 1 too: land on zero, never wrap
          w_count_nxt    = 32'd0;
          w_fsm_set_flag = 1'b1;
          w_state_nxt    = ST_INT;
        end
      end
      ST_INT: begin
        w_state_nxt = ST_IDLE;
        if (w_reload) w_fsm_clr_flag = 1'b1;
        else          w_fsm_clr_en   = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Bus/FSM arbitration for the architectural registers
  always_comb begin
    w_ctrl_nxt = r_ctrl;
    if (w_ctrl_wr) begin
      // CPU write beats the FSM's EN clear on the same edge
      if (byteen[0]) w_ctrl_nxt = wdata[CTRL_WIDTH-1:0];
    end else if (w_fsm_clr_en) begin
      w_ctrl_nxt[CTRL_EN] = 1'b0;
    end

    w_preset_nxt = r_preset;
    if (w_preset_wr) w_preset_nxt = merge_bytes(r_preset, wdata, byteen);

    // A terminal count setting the flag is never lost to a coincident CTRL write
    w_intflag_nxt = r_intflag;
    if (w_fsm_set_flag)                    w_intflag_nxt = 1'b1;
    else if (w_fsm_clr_flag || w_ctrl_wr)  w_intflag_nxt = 1'b0;
  end

  // Register file, flag and irq flop; irq tracks next flag AND next IM so it aligns with INTFLAG
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ctrl    <= '0;
      r_preset  <= '0;
      r_count   <= '0;
      r_intflag <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_ctrl    <= w_ctrl_nxt;
      r_preset  <= w_preset_nxt;
      r_count   <= w_count_nxt;
      r_intflag <= w_intflag_nxt;
      r_irq     <= w_intflag_nxt & w_ctrl_nxt[CTRL_IM];
    end
  end

  // Read mux; the reserved slot reads zero
  always_comb begin
    rdata = 32'd0;
    case (idx)
      REG_CTRL:   rdata = {{(32-CTRL_WIDTH){1'b0}}, r_ctrl};
      REG_PRESET: rdata = r_preset;
      REG_COUNT:  rdata = r_count;
      REG_RSVD:   rdata = 32'd0;
      default:    rdata = 32'd0;
    endcase
  end

  assign irq = r_irq;

endmodule : timer_counter_core
`default_nettype wire

// File: rtl/timer_counter.sv
`default_nettype none
// ============================================================================
// timer_counter
//   Two-channel MMIO timer. Each channel decodes addr[1:0] as its register
//   index; addr[2] picks the channel (TC0 at 0, TC1 at 1). The interrupt is
//   the OR of the two registered channel interrupts.
//   Rev 1.0 - initial release
// ============================================================================
module timer_counter
  import timer_counter_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic [29:0] addr,
  input  logic        we,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic        w_sel1;
  logic [31:0] w_rdata0, w_rdata1;
  logic        w_irq0, w_irq1;
  logic        w_unused_addr;

  assign w_sel1        = addr[2];
  assign w_unused_addr = ^addr[29:3];

  timer_counter_core TC0 (
    .clk    (clk),
    .resetn (resetn),
    .idx    (addr[1:0]),
    .we     (we & ~w_sel1),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (w_rdata0),
    .irq    (w_irq0)
  );

  timer_counter_core TC1 (
    .clk    (clk),
    .resetn (resetn),
    .idx    (addr[1:0]),
    .we     (we & w_sel1),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (w_rdata1),
    .irq    (w_irq1)
  );

  assign rdata = w_sel1 ? w_rdata1 : w_rdata0;
  assign irq   = w_irq0 | w_irq1;

endmodule : timer_counter
`default_nettype wire

// File: tb/tb_timer_counter.sv
`default_nettype none
// ============================================================================
// tb_timer_counter
//   Directed self-checking bench for the two-channel MMIO timer.
//   Rev 1.0 - initial release
// ============================================================================
module tb_timer_counter;

  logic        clk;
  logic        resetn;
  logic [29:0] addr;
  logic        we;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int tests = 0;
  int fails = 0;

  timer_counter dut (
    .clk    (clk),
    .resetn (resetn),
    .addr   (addr),
    .we     (we),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [29:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    chk(tag, {31'd0, irq}, {31'd0, exp});
  endtask

  // One bus write, committed on the next rising edge
  task automatic wr(input logic [29:0] a, input logic [3:0] be, input logic [31:0] d);
    addr   = a;
    byteen = be;
    wdata  = d;
    we     = 1'b1;
    tick();
    we     = 1'b0;
    byteen = 4'h0;
  endtask

  initial begin
    resetn = 1'b0;
    addr   = '0;
    we     = 1'b0;
    byteen = 4'h0;
    wdata  = '0;

    // Reset state
    tick();
    tick();
    rd("rst CTRL", 30'd0, 32'h0);
    rd("rst PRESET", 30'd1, 32'h0);
    rd("rst COUNT", 30'd2, 32'h0);
    chk_irq("rst irq", 1'b0);
    resetn = 1'b1;

    // One-shot, PRESET=5, IM=1
    wr(30'd1, 4'hF, 32'd5);
    wr(30'd0, 4'hF, 32'h9);                 // E0
    tick(); tick();                         // E1, E2
    rd("A count E2", 30'd2, 32'd5);
    for (int k = 4; k >= 1; k--) begin      // E3..E6
      tick();
      rd("A count dec", 30'd2, 32'(k));
      chk_irq("A irq quiet", 1'b0);
    end
    tick();                                 // E7
    chk_irq("A irq E7", 1'b1);
    rd("A count E7", 30'd2, 32'd0);
    tick();                                 // E8
    rd("A EN cleared E8", 30'd0, 32'h8);
    chk_irq("A irq E8", 1'b1);
    tick(); tick();
    chk_irq("A irq held", 1'b1);
    wr(30'd0, 4'hF, 32'h8);
    chk_irq("A irq cleared", 1'b0);
    rd("A CTRL after clr", 30'd0, 32'h8);
    rd("A TC1 untouched", 30'd4, 32'h0);

    // Byte lanes, read-only COUNT, reserved slot, CTRL upper bits
    wr(30'd1, 4'hF, 32'h11223344);
    wr(30'd1, 4'b0010, 32'hAABBCCDD);
    rd("B PRESET lane1", 30'd1, 32'h1122CC44);
    wr(30'd1, 4'b0000, 32'hFFFFFFFF);
    rd("B PRESET be0", 30'd1, 32'h1122CC44);
    wr(30'd2, 4'hF, 32'hDEADBEEF);
    rd("B COUNT ro", 30'd2, 32'h0);
    wr(30'd3, 4'hF, 32'hDEADBEEF);
    rd("B RSVD zero", 30'd3, 32'h0);
    wr(30'd0, 4'hF, 32'hFFFFFFF0);
    rd("B CTRL hi ignored", 30'd0, 32'h0);

    // Mid-count disable then re-enable
    wr(30'd1, 4'hF, 32'd6);
    wr(30'd0, 4'hF, 32'h9);                 // E0
    tick(); tick(); tick();                 // E1..E3
    rd("C count E3", 30'd2, 32'd5);
    wr(30'd0, 4'hF, 32'h0);                 // E4: decrements to 4, EN off
    rd("C count at wr", 30'd2, 32'd4);
    tick(); tick();
    rd("C count held", 30'd2, 32'd4);
    chk_irq("C no irq", 1'b0);
    wr(30'd0, 4'hF, 32'h9);
    tick(); tick();
    rd("C reload", 30'd2, 32'd6);
    wr(30'd0, 4'hF, 32'h0);
    tick();

    // Auto-reload, PRESET=3: flag after E5 and E11
    wr(30'd1, 4'hF, 32'd3);
    wr(30'd0, 4'hF, 32'hB);                 // E0
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk_irq("D irq pulse", (c == 5) || (c == 11));
      if (c == 8) rd("D count reload", 30'd2, 32'd3);
      if (c == 6) rd("D CTRL kept", 30'd0, 32'hB);
    end
    wr(30'd0, 4'hF, 32'h0);
    tick();

    // PRESET=0, write-wins on EN clear, IM=0 variant
    wr(30'd1, 4'hF, 32'd0);
    wr(30'd0, 4'hF, 32'h9);                 // E0
    tick(); tick();                         // E1, E2
    chk_irq("E irq E2", 1'b0);
    tick();                                 // E3
    chk_irq("E irq E3", 1'b1);
    rd("E count zero", 30'd2, 32'd0);
    wr(30'd0, 4'hF, 32'h9);                 // E4 in INT: write wins
    rd("E CTRL write wins", 30'd0, 32'h9);
    chk_irq("E irq cleared", 1'b0);
    tick(); tick(); tick();                 // E5..E7
    chk_irq("E irq again", 1'b1);
    wr(30'd0, 4'hF, 32'h1);                 // E8 in INT: IM off, EN kept
    rd("E CTRL IM0", 30'd0, 32'h1);
    tick(); tick(); tick();                 // E9..E11 flag sets
    chk_irq("E IM0 no irq", 1'b0);
    tick();                                 // E12 INT clears EN
    rd("E EN cleared", 30'd0, 32'h0);
    chk_irq("E IM0 still 0", 1'b0);

    // Second channel on its own
    wr(30'd5, 4'hF, 32'd2);
    wr(30'd4, 4'hF, 32'h9);                 // E0
    tick(); tick();                         // E2
    rd("F TC1 count", 30'd6, 32'd2);
    rd("F TC0 CTRL", 30'd0, 32'h0);
    tick(); tick();                         // E4
    chk_irq("F TC1 irq", 1'b1);
    wr(30'd4, 4'hF, 32'h0);
    chk_irq("F TC1 irq clr", 1'b0);

    // Reset mid-count with a concurrent write
    wr(30'd1, 4'hF, 32'd5);
    wr(30'd0, 4'hF, 32'h9);                 // E0
    tick(); tick(); tick(); tick(); tick(); // E5: COUNT=2
    rd("G count 2", 30'd2, 32'd2);
    resetn = 1'b0;
    addr   = 30'd1;
    wdata  = 32'hFFFFFFFF;
    byteen = 4'hF;
    we     = 1'b1;
    tick();
    we     = 1'b0;
    byteen = 4'h0;
    resetn = 1'b1;
    rd("G CTRL", 30'd0, 32'h0);
    rd("G PRESET", 30'd1, 32'h0);
    rd("G COUNT", 30'd2, 32'h0);
    chk_irq("G irq", 1'b0);
    tick(); tick(); tick();
    chk_irq("G no late irq", 1'b0);
    rd("G COUNT idle", 30'd2, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_timer_counter
`default_nettype wire

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 Parameters: none; the block is a fixed 32-bit, three-register MMIO timer.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 resetn  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 addr  input  30  word address (byte address bits 31:2); only addr[1:0] (byte bits 3:2) are decoded.
REQ-005 we  input  1  write strobe from the bus bridge, already qualified by range decode.
REQ-006 byteen  input  4  byte lanes for the write; bit i enables wdata[8i+7:8i].
REQ-007 wdata  input  32  write data.
REQ-008 rdata  output  32  read data, combinational from addr and current register state.
REQ-009 irq  output  1  interrupt request, registered.

Function
REQ-010 Register map (word index): 0 CTRL (R/W), 1 PRESET (R/W), 2 COUNT (read-only), 3 reserved.
REQ-011 CTRL bits: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 10/11 SHALL behave as 00), [3] IM (interrupt mask, 1 = enabled); bits 31:4 SHALL read 0 and ignore writes.
REQ-012 A write (we=1) SHALL update only the byte lanes enabled in byteen; we=1 with byteen=0 SHALL change nothing.
REQ-013 Writes to COUNT and reserved index 3 SHALL be ignored; reads of index 3 SHALL return 0.
REQ-014 FSM states IDLE, LOAD, CNT, INT; the FSM SHALL evaluate register values as they were before the current edge.
REQ-015 IDLE: EN=1 -> LOAD; else stay.
REQ-016 LOAD: COUNT <= PRESET; -> CNT.
REQ-017 CNT: EN=0 -> IDLE with COUNT held; else COUNT>1 -> COUNT-1, stay; else COUNT<=0, set INTFLAG, -> INT.
REQ-018 INT: -> IDLE; MODE one-shot clears EN; MODE auto-reload clears INTFLAG on this edge (one-cycle flag).
REQ-019 In one-shot mode INTFLAG SHALL remain set until any CTRL write or reset.
REQ-020 irq SHALL equal INTFLAG AND IM, both registered, with no combinational path from the bus.
REQ-021 A CPU write to CTRL on the same edge the FSM clears EN SHALL win (written value retained).
REQ-022 PRESET writes during CNT SHALL not alter COUNT; the new value SHALL take effect at the next LOAD.
REQ-023 PRESET=0 or 1: LOAD yields COUNT=PRESET, next CNT edge enters INT (no underflow, no wrap).
REQ-024 Latency: EN written at edge E0 with PRESET=P>=1 -> COUNT=P after E2, COUNT=0 and INTFLAG set after E(P+2).
REQ-025 Auto-reload period SHALL be P+3 cycles between INTFLAG assertions for P>=1.

Reset
REQ-026 With resetn=0 at a rising edge: CTRL=0, PRESET=0, COUNT=0, INTFLAG=0, state=IDLE, irq=0; bus writes on that edge SHALL be ignored.
REQ-027 Reset during CNT or INT SHALL abort counting with no irq pulse after the reset edge.

Structure
REQ-028 Shared package/header SHALL hold register word indices, CTRL bit positions, MODE encodings, and FSM state encodings, for reuse by the bridge and bench.
REQ-029 No sub-module; register file and FSM in one module, instantiated twice (TC0, TC1) by the top level.

Verification
REQ-030 PRESET=5, CTRL=0x9 at E0 -> COUNT 5,4,3,2,1 after E2..E6; irq=1 after E7; EN=0 after E8; irq stays 1 until CTRL write 0x8 clears it.
REQ-031 PRESET=3, CTRL=0xB (auto-reload, IM) -> irq one-cycle pulses every 6 cycles, COUNT reloaded to 3 each period.
REQ-032 Mid-count CTRL=0x0 write at COUNT=4 -> next edge IDLE, COUNT holds 4, no irq; re-enable -> reload from PRESET.
REQ-033 byteen=0b0010, wdata=0xAABBCCDD to PRESET=0x11223344 -> PRESET=0x1122CC44; write to COUNT -> unchanged.
REQ-034 PRESET=0, CTRL=0x9 -> irq=1 after E3; IM=0 variant -> INTFLAG sets, irq stays 0.
REQ-035 resetn=0 asserted while COUNT=2 in CNT -> all registers 0, irq=0 after that edge; concurrent we ignored.
